// File: rtl/audio_pkg.sv
// audio_pkg: WM8731 register map, boot write table and sequencer state encoding
package audio_pkg;
  localparam logic [6:0] R_LLIN   = 7'h00;
  localparam logic [6:0] R_RLIN   = 7'h01;
  localparam logic [6:0] R_LHP    = 7'h02;
  localparam logic [6:0] R_RHP    = 7'h03;
  localparam logic [6:0] R_APATH  = 7'h04;
  localparam logic [6:0] R_DPATH  = 7'h05;
  localparam logic [6:0] R_PWR    = 7'h06;
  localparam logic [6:0] R_IFACE  = 7'h07;
  localparam logic [6:0] R_SRATE  = 7'h08;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;
  // soft reset first, then R0..R9 in order; each entry is {reg[6:0], data[8:0]}
  localparam int NUM_REGS = 11;
  localparam logic [15:0] CFG_TABLE [NUM_REGS] = '{
    {R_RESET,  9'h000},
    {R_LLIN,   9'h017},
    {R_RLIN,   9'h017},
    {R_LHP,    9'h079},
    {R_RHP,    9'h079},
    {R_APATH,  9'h012},
    {R_DPATH,  9'h000},
    {R_PWR,    9'h000},
    {R_IFACE,  9'h04A},
    {R_SRATE,  9'h000},
    {R_ACTIVE, 9'h001}
  };
  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, GAP, DONE, ERR} st_t;
  function automatic logic is_op(st_t s);
    return s inside {START, BYTE, ACK, STOP, GAP};
  endfunction
endpackage

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: quarter-tick divider and SCLK/SDAT phase generation for START, BYTE, ACK, STOP and GAP ops
module i2c_bit_engine
  import audio_pkg::*;
#(
  parameter int DIV = 125,
  parameter int GAP_TICKS = 8
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       go,
  input  st_t        cmd,
  input  logic [7:0] byte_in,
  input  logic       sdat_i,
  output logic       step,
  output logic       ack,
  output logic       I2C_SCLK,
  output logic       sdat_oe
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  logic [4:0] qc, len;
  logic [7:0] sh;
  logic [1:0] sync;
  logic act, tick, hi;
  st_t op;
  // each bit is low/high/high/low quarters; data only moves at quarter 0 while SCLK is low
  always_comb begin
    tick = cnt == CW'(DIV - 1);
    len = op == BYTE ? 5'd31 : op == GAP ? 5'(GAP_TICKS - 1) : 5'd3;
    step = tick && (!act || qc == len);
    hi = qc[0] ^ qc[1];
    I2C_SCLK = !act ? 1'b1 : op == START ? qc[1:0] != 2'd3 : op == STOP ? qc[1:0] != 2'd0 :
               (op == BYTE || op == ACK) ? hi : 1'b1;
    sdat_oe = !act ? 1'b0 : op == START ? qc[1:0] != 2'd0 : op == STOP ? !qc[1] :
              op == BYTE ? !sh[~qc[4:2]] : 1'b0;
  end
  // free-running quarter-tick divider
  always_ff @(posedge MCLK or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  // load the next op on a step boundary, otherwise advance the quarter count
  always_ff @(posedge MCLK or posedge reset)
    if (reset) begin
      act <= 1'b0;
      op <= IDLE;
      qc <= '0;
      sh <= '0;
    end else if (step) begin
      act <= go;
      op <= cmd;
      qc <= '0;
      sh <= byte_in;
    end else if (tick) qc <= qc + 5'd1;
  // pad synchroniser; ACK is sampled at the end of the second high quarter
  always_ff @(posedge MCLK or posedge reset)
    if (reset) begin
      sync <= 2'b11;
      ack <= 1'b1;
    end else begin
      sync <= {sync[0], sdat_i};
      if (tick && act && op == ACK && qc == 5'd2) ack <= sync[1];
    end
endmodule

// File: rtl/wm8731_cfg_ctrl.sv
// wm8731_cfg_ctrl: boot-time WM8731 register table writer over I2C; CFG_RETRY_EN re-sends NACKed entries
module wm8731_cfg_ctrl
  import audio_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 100_000,
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int GAP_TICKS = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       start,
  output logic       I2C_SCLK,
  output logic       sdat_oe,
  input  logic       sdat_i,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] cur_idx
);
`ifdef CFG_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif
  st_t st, st_nxt;
  logic [3:0] idx, rty;
  logic [1:0] bcnt, bsel;
  logic [15:0] ent;
  logic [7:0] tx;
  logic nack, req, step, ack, go, retry_ok, last_ent;
  // state names the op the bit engine is running; the next op is handed over on each step
  always_comb begin
    ent = CFG_TABLE[idx];
    bsel = st == ACK ? bcnt + 2'd1 : 2'd0;
    tx = bsel == 2'd0 ? {DEV_ADDR, 1'b0} : bsel == 2'd1 ? ent[15:8] : ent[7:0];
    retry_ok = rty != 4'(RETRIES);
    last_ent = idx == 4'(NUM_REGS - 1);
    st_nxt = st;
    if (step)
      case (st)
        IDLE:    st_nxt = req ? START : IDLE;
        START:   st_nxt = BYTE;
        BYTE:    st_nxt = ACK;
        ACK:     st_nxt = (ack || bcnt == 2'd2) ? STOP : BYTE;
        STOP:    st_nxt = (nack && !retry_ok) ? ERR : GAP;
        GAP:     st_nxt = (!nack && last_ent) ? DONE : START;
        default: st_nxt = IDLE;
      endcase
    go = is_op(st_nxt);
  end
  // table walk, retry count and sticky status; an idle start pulse restarts from entry 0
  always_ff @(posedge MCLK or posedge reset)
    if (reset) begin
      st <= IDLE;
      idx <= '0;
      rty <= '0;
      bcnt <= '0;
      nack <= 1'b0;
      req <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      st <= st_nxt;
      if (step && st == IDLE) req <= 1'b0;
      if (step && st == START) bcnt <= 2'd0;
      if (step && st == ACK) begin
        bcnt <= bcnt + 2'd1;
        nack <= ack;
      end
      if (step && st == STOP && nack && retry_ok) rty <= rty + 4'd1;
      if (step && st == GAP && !nack) begin
        rty <= '0;
        idx <= last_ent ? idx : idx + 4'd1;
      end
      if (st == GAP && st_nxt == DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (st == STOP && st_nxt == ERR) begin
        error <= 1'b1;
        busy <= 1'b0;
      end
      if (start && !busy) begin
        busy <= 1'b1;
        req <= 1'b1;
        done <= 1'b0;
        error <= 1'b0;
        idx <= '0;
        rty <= '0;
      end
    end
  assign cur_idx = idx;
  i2c_bit_engine #(.DIV(CLK_HZ / (4 * I2C_HZ)), .GAP_TICKS(GAP_TICKS)) u_eng (
    .MCLK(MCLK),
    .reset(reset),
    .go(go),
    .cmd(st_nxt),
    .byte_in(tx),
    .sdat_i(sdat_i),
    .step(step),
    .ack(ack),
    .I2C_SCLK(I2C_SCLK),
    .sdat_oe(sdat_oe)
  );
endmodule
